// File: rtl/ex_muldiv_stage.sv
// Execute stage: ALU, destination select and an iterative 32-step MULTU/DIVU
// unit with HI/LO. While the unit owns the stage, stall holds the upstream
// pipeline registers and a bubble goes forward to EX/MEM.
module ex_muldiv_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      WB_in,
    input  logic [1:0]      MEM_in,
    input  logic [3:0]      EX_in,
    input  logic [4:0]      shamt_in,
    input  logic [5:0]      funct_in,
    input  logic [XLEN-1:0] RD1_in,
    input  logic [XLEN-1:0] RD2_in,
    input  logic [XLEN-1:0] immed_in,
    input  logic [4:0]      rt_in,
    input  logic [4:0]      rd_in,
    output logic [1:0]      WB_out,
    output logic [1:0]      MEM_out,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] wdata_out,
    output logic [4:0]      wreg_out,
    output logic            stall,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    localparam int unsigned CntW = $clog2(MD_CYCLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(MD_CYCLES - 1);

    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDivu  = 6'b011011;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    // acc_hi/acc_lo: partial product (multu) or remainder/quotient (divu)
    logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
    // multiplicand or divisor
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              is_div_q, is_div_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic [1:0]        alu_op;
    logic [XLEN-1:0]   op_b;
    logic              md_op;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;

    assign alu_op = EX_in[2:1];
    assign op_b   = EX_in[0] ? immed_in : RD2_in;
    assign md_op  = (alu_op == 2'b10) && ((funct_in == FnMultu) || (funct_in == FnDivu));

    // One multiply step: add multiplicand when the low multiplier bit is set
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    // One restoring-divide step; a zero divisor always "fits", which yields
    // an all-ones quotient and the dividend as remainder
    assign div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = div_shift >= {1'b0, opnd_q};

    // Sequencer and HI/LO state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Next-state: latch operands, iterate MD_CYCLES steps, commit HI/LO
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            StIdle: begin
                if (md_op) begin
                    state_d  = StBusy;
                    count_d  = '0;
                    acc_hi_d = '0;
                    acc_lo_d = RD1_in;
                    opnd_d   = op_b;
                    is_div_d = (funct_in == FnDivu);
                end
            end
            StBusy: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                    acc_lo_d = {acc_lo_q[XLEN-2:0], div_ge};
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[XLEN-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                hi_d    = acc_hi_q;
                lo_d    = acc_lo_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // ALU result selection
    always_comb begin
        alu_out = '0;
        case (alu_op)
            2'b00: alu_out = RD1_in + op_b;
            2'b01: alu_out = RD1_in - op_b;
            2'b11: alu_out = RD1_in | {{(XLEN-16){1'b0}}, immed_in[15:0]};
            default: begin
                case (funct_in)
                    6'b100000, 6'b100001: alu_out = RD1_in + op_b;
                    6'b100010, 6'b100011: alu_out = RD1_in - op_b;
                    6'b100100: alu_out = RD1_in & op_b;
                    6'b100101: alu_out = RD1_in | op_b;
                    6'b100110: alu_out = RD1_in ^ op_b;
                    6'b100111: alu_out = ~(RD1_in | op_b);
                    6'b101010: alu_out = {{(XLEN-1){1'b0}}, ($signed(RD1_in) < $signed(op_b))};
                    6'b101011: alu_out = {{(XLEN-1){1'b0}}, (RD1_in < op_b)};
                    6'b000000: alu_out = op_b << shamt_in;
                    6'b000010: alu_out = op_b >> shamt_in;
                    6'b000011: alu_out = $signed(op_b) >>> shamt_in;
                    6'b010000: alu_out = hi_q;
                    6'b010010: alu_out = lo_q;
                    default:   alu_out = '0;
                endcase
            end
        endcase
    end

    assign stall     = ((state_q == StIdle) && md_op) || (state_q == StBusy);
    assign WB_out    = stall ? 2'b00 : WB_in;
    assign MEM_out   = stall ? 2'b00 : MEM_in;
    assign wdata_out = RD2_in;
    assign wreg_out  = EX_in[3] ? rd_in : rt_in;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule
